// File: rtl/mc_datapath_if.sv
// Unified instruction/data memory port of the multi-cycle datapath.
interface mc_datapath_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mc_datapath.sv
// Multi-cycle 32-bit MIPS subset datapath with integrated control FSM and a
// single memory port shared by instruction fetch and load/store.
module mc_datapath #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    mc_datapath_if.master        bus,
    output logic [31:0]          PC,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] retired,
    output logic                 illegal_instr
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t      st, nst;
    logic [31:0] pc_q, ir, a, b, t, alu_out, mdr;
    logic [31:0] regs [32];
    logic [31:0] alu_res;
    logic        retire;

    // Instruction fields and classification
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sx;
    logic        is_r, r_ok, is_lw, is_sw, is_beq, is_addi, is_j, legal;

    assign op      = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign funct   = ir[5:0];
    assign imm_sx  = {{16{ir[15]}}, ir[15:0]};
    assign is_r    = (op == 6'b000000);
    assign r_ok    = (funct == 6'b100000) || (funct == 6'b100010) || (funct == 6'b100100) ||
                     (funct == 6'b100101) || (funct == 6'b101010);
    assign is_lw   = (op == 6'b100011);
    assign is_sw   = (op == 6'b101011);
    assign is_beq  = (op == 6'b000100);
    assign is_addi = (op == 6'b001000);
    assign is_j    = (op == 6'b000010);
    assign legal   = (is_r && r_ok) || is_lw || is_sw || is_beq || is_addi || is_j;

    assign PC      = pc_q;
    assign state   = st;

    // ALU: R-type ops by funct, otherwise base + sign-extended immediate
    always_comb begin
        alu_res = a + imm_sx;
        if (is_r) begin
            case (funct)
                6'b100010: alu_res = a - b;
                6'b100100: alu_res = a & b;
                6'b100101: alu_res = a | b;
                6'b101010: alu_res = {31'b0, ($signed(a) < $signed(b))};
                default:   alu_res = a + b;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) st <= S_FETCH;
        else       st <= nst;
    end

    // Next state, memory port drive, retire and illegal pulses
    always_comb begin
        nst           = st;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = pc_q;
        bus.mem_wdata = b;
        illegal_instr = 1'b0;
        retire        = 1'b0;
        case (st)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) nst = S_DECODE;
            end
            S_DECODE: begin
                if (is_j) begin
                    nst    = S_FETCH;
                    retire = 1'b1;
                end else if (!legal) begin
                    nst           = S_FETCH;
                    illegal_instr = 1'b1;
                end else begin
                    nst = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    nst    = S_FETCH;
                    retire = 1'b1;
                end else if (is_lw || is_sw) nst = S_MEM;
                else                          nst = S_WB;
            end
            S_MEM: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = alu_out;
                bus.mem_we   = is_sw;
                if (bus.mem_ready) begin
                    if (is_sw) begin
                        nst    = S_FETCH;
                        retire = 1'b1;
                    end else nst = S_WB;
                end
            end
            S_WB: begin
                nst    = S_FETCH;
                retire = 1'b1;
            end
            default: nst = S_FETCH;
        endcase
        // Reset abandons any transaction and suppresses all side effects
        if (reset) begin
            bus.mem_req   = 1'b0;
            bus.mem_we    = 1'b0;
            illegal_instr = 1'b0;
            retire        = 1'b0;
        end
    end

    // Datapath registers, register file and retired counter
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            t       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            retired <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            if (retire) retired <= retired + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            case (st)
                S_FETCH: if (bus.mem_ready) begin
                    ir   <= bus.mem_rdata;
                    pc_q <= pc_q + 32'd4;
                end
                S_DECODE: begin
                    // $0 is never written, so it always reads as zero
                    a <= regs[rs];
                    b <= regs[rt];
                    t <= pc_q + (imm_sx << 2);
                    if (is_j) pc_q <= {pc_q[31:28], ir[25:0], 2'b00};
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    if (is_beq && (a == b)) pc_q <= t;
                end
                S_MEM: if (bus.mem_ready && is_lw) mdr <= bus.mem_rdata;
                S_WB: begin
                    if (is_r && rd != 5'd0)                 regs[rd] <= alu_out;
                    else if (is_addi && rt != 5'd0)         regs[rt] <= alu_out;
                    else if (is_lw && rt != 5'd0)           regs[rt] <= mdr;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter CNT_WIDTH, 32: width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high; SHALL act only on a rising clk edge.
REQ-005 mem_req  output  1  memory transaction request.
REQ-006 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-007 mem_addr  output  32  byte address; valid while mem_req=1.
REQ-008 mem_wdata  output  32  store data; valid while mem_req=1 and mem_we=1.
REQ-009 mem_rdata  input  32  read data; sampled in the cycle mem_ready=1.
REQ-010 mem_ready  input  1  transaction completes in any cycle with mem_req=1 and mem_ready=1.
REQ-011 PC  output  32  current program counter.
REQ-012 state  output  3  FSM state, for debug.
REQ-013 retired  output  CNT_WIDTH  count of completed legal instructions.
REQ-014 illegal_instr  output  1  one-cycle pulse on an unsupported opcode/funct.

Function
REQ-015 The block SHALL be a multi-cycle 32-bit MIPS datapath with an integrated control FSM and a single unified instruction/data memory port.
REQ-016 Supported instructions SHALL be: R-type (op 000000) add 100000, sub 100010, and 100100, or 100101, slt 101010; lw 100011; sw 101011; beq 000100; addi 001000; j 000010.
REQ-017 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-018 FETCH: drive mem_req=1, mem_we=0, mem_addr=PC; hold until mem_ready=1, then latch IR<=mem_rdata, PC<=PC+4, go to DECODE.
REQ-019 DECODE: latch A<=rs, B<=rt and target T<=PC+(sext(imm)<<2), where PC already equals old PC+4; j SHALL set PC<={PC[31:28],IR[25:0],2'b00} and return to FETCH; illegal op SHALL pulse illegal_instr and return to FETCH; others go to EXEC.
REQ-020 EXEC: R-type/addi compute ALUOut, go to WB; lw/sw compute ALUOut=A+sext(imm), go to MEM; beq SHALL set PC<=T if A==B, then return to FETCH.
REQ-021 MEM: drive mem_req=1, mem_addr=ALUOut, mem_we=1 for sw with mem_wdata=B; hold until mem_ready=1; sw then returns to FETCH, lw latches MDR<=mem_rdata and goes to WB.
REQ-022 WB: write ALUOut to rd (R-type) or rt (addi), MDR to rt (lw); return to FETCH.
REQ-023 mem_addr, mem_we and mem_wdata SHALL be stable for every cycle mem_req=1 until completion; mem_req SHALL be 0 in DECODE, EXEC and WB.
REQ-024 With mem_ready tied 1, cycle counts SHALL be: j 2, beq 3, sw 4, R-type/addi 4, lw 5; illegal 2; each wait cycle adds one.
REQ-025 Arithmetic SHALL be 32-bit modulo 2^32 with no overflow trap; slt SHALL be signed; immediates SHALL be sign-extended.
REQ-026 Register $0 SHALL read as zero; writes to $0 SHALL be discarded.
REQ-027 retired SHALL increment by 1 in the final cycle of each legal instruction, wrap at 2^CNT_WIDTH, and never increment for illegal instructions.

Reset
REQ-028 While reset=1 at an edge: PC<=RESET_PC, state<=FETCH, IR/A/B/ALUOut/MDR<=0, all 32 registers<=0, retired<=0.
REQ-029 mem_req and illegal_instr SHALL be 0 in any cycle where reset=1.
REQ-030 Reset in FETCH/MEM SHALL abandon the transaction with no write issued; reset in WB SHALL suppress the register write.

Verification
REQ-031 mem_ready=1, program addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sw $3,0x40($0) -> write with addr 0x40, data 0x00000002 in cycle 16; retired=4.
REQ-032 mem_ready delayed 3 cycles per request -> FETCH lasts 3 cycles, mem_addr constant throughout, instruction otherwise identical.
REQ-033 beq $1,$1,-1 at 0x10 -> PC returns to 0x10; beq $1,$2 with unequal values -> PC=0x14.
REQ-034 j 0x0000100 at 0x0 -> PC=0x400 after 2 cycles; opcode 111111 -> illegal_instr pulse, PC+4, retired unchanged.
REQ-035 lw $0,0x40($0) with mem_rdata 0xDEADBEEF, then sw $0,0x44($0) -> write data 0x00000000.
REQ-036 reset asserted during MEM of sw -> mem_req=0 that cycle, no write, PC=RESET_PC and retired=0 next cycle.
